// File: rtl/aes_axi_stream_slave.sv
// rtl/aes_axi_stream_slave.sv - AXI-Stream slave packing 32-bit words into 128-bit AES blocks for an input FIFO.
// Optional macro AES_AXIS_SLAVE_PAD_EN: zero-pad short tlast blocks instead of dropping them.

module sync_fifo #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_tvalid,
    input  logic [DATA_WIDTH-1:0] write_tdata,
    output logic                  read_tvalid,
    input  logic                  read_tready,
    output logic [DATA_WIDTH-1:0] read_tdata,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign do_push     = write_tvalid && !full;
    assign do_pop      = read_tready && !empty;
    assign empty       = (count == '0);
    assign full        = (count == (ADDR_WIDTH+1)'(DEPTH));
    assign almost_full = (count >= (ADDR_WIDTH+1)'(DEPTH - 1));
    assign read_tvalid = !empty;
    assign read_tdata  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= write_tdata;
        end
    end

endmodule

module aes_axi_stream_slave #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_SIZE            = 16,
    parameter int FIFO_ADDR_WIDTH      = 4,
    parameter int FIFO_DATA_WIDTH      = 128
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_aresetn,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                              s00_axis_tvalid,
    input  logic                              s00_axis_tlast,
    output logic                              s00_axis_tready,
    input  logic                              in_fifo_read_tready,
    output logic                              in_fifo_read_tvalid,
    output logic [FIFO_DATA_WIDTH-1:0]        in_fifo_data,
    output logic                              in_fifo_empty,
    output logic                              in_fifo_full,
    output logic                              in_fifo_almost_full,
    output logic                              axis_slave_done,
    output logic                              axis_slave_err
);

    localparam int W = C_S_AXIS_TDATA_WIDTH;

    typedef enum logic [0:0] {S_COLLECT, S_PUSH} state_t;

    state_t                     state;
    state_t                     next_state;
    logic [FIFO_DATA_WIDTH-1:0] blk;
    logic [FIFO_DATA_WIDTH-1:0] blk_shifted;
    logic [1:0]                 word_cnt;
    logic                       accept;
    logic                       fifo_write_tvalid;
    logic                       unused_tstrb;

    assign unused_tstrb    = ^s00_axis_tstrb;
    assign s00_axis_tready = s00_axis_aresetn && (state == S_COLLECT) && !in_fifo_full;
    assign accept          = s00_axis_tvalid && s00_axis_tready;
    assign blk_shifted     = {blk[FIFO_DATA_WIDTH-W-1:0], s00_axis_tdata};

`ifdef AES_AXIS_SLAVE_PAD_EN
    logic [FIFO_DATA_WIDTH-1:0] blk_padded;

    // Words already received stay MSW-first; the missing low words become zero.
    always_comb begin
        blk_padded = blk_shifted;
        case (word_cnt)
            2'd0:    blk_padded = {s00_axis_tdata, {(FIFO_DATA_WIDTH-W){1'b0}}};
            2'd1:    blk_padded = {blk[W-1:0], s00_axis_tdata, {(FIFO_DATA_WIDTH-2*W){1'b0}}};
            2'd2:    blk_padded = {blk[2*W-1:0], s00_axis_tdata, {W{1'b0}}};
            default: blk_padded = blk_shifted;
        endcase
    end
`endif

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            state <= S_COLLECT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state        = state;
        fifo_write_tvalid = 1'b0;
        case (state)
            S_COLLECT: begin
                if (accept) begin
                    if (word_cnt == 2'd3) begin
                        next_state = S_PUSH;
                    end
`ifdef AES_AXIS_SLAVE_PAD_EN
                    else if (s00_axis_tlast) begin
                        next_state = S_PUSH;
                    end
`endif
                end
            end
            S_PUSH: begin
                fifo_write_tvalid = s00_axis_aresetn;
                next_state        = S_COLLECT;
            end
            default: next_state = S_COLLECT;
        endcase
    end

    // done/err are registered at acceptance so they land in the following cycle.
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            blk             <= '0;
            word_cnt        <= 2'd0;
            axis_slave_done <= 1'b0;
            axis_slave_err  <= 1'b0;
        end else begin
            axis_slave_done <= 1'b0;
            axis_slave_err  <= 1'b0;
            if (accept) begin
                word_cnt <= word_cnt + 2'd1;
                blk      <= blk_shifted;
                if (word_cnt == 2'd3) begin
                    axis_slave_done <= s00_axis_tlast;
                end else if (s00_axis_tlast) begin
                    word_cnt <= 2'd0;
`ifdef AES_AXIS_SLAVE_PAD_EN
                    blk             <= blk_padded;
                    axis_slave_done <= 1'b1;
`else
                    blk             <= '0;
                    axis_slave_err  <= 1'b1;
`endif
                end
            end
        end
    end

    sync_fifo #(
        .ADDR_WIDTH (FIFO_ADDR_WIDTH),
        .DATA_WIDTH (FIFO_DATA_WIDTH),
        .DEPTH      (FIFO_SIZE)
    ) u_fifo (
        .clk          (s00_axis_aclk),
        .rst          (!s00_axis_aresetn),
        .write_tvalid (fifo_write_tvalid),
        .write_tdata  (blk),
        .read_tvalid  (in_fifo_read_tvalid),
        .read_tready  (in_fifo_read_tready),
        .read_tdata   (in_fifo_data),
        .empty        (in_fifo_empty),
        .full         (in_fifo_full),
        .almost_full  (in_fifo_almost_full)
    );

endmodule

// File: tb/tb_aes_axi_stream_slave.sv
// tb/tb_aes_axi_stream_slave.sv - self-checking bench for aes_axi_stream_slave with a word-queue reference model.
module tb_aes_axi_stream_slave;

`ifdef AES_AXIS_SLAVE_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic [31:0]  tdata = '0;
    logic [3:0]   tstrb = '0;
    logic         tvalid = 1'b0;
    logic         tlast = 1'b0;
    logic         tready;
    logic         rd_tready = 1'b0;
    logic         rd_tvalid;
    logic [127:0] rd_data;
    logic         f_empty;
    logic         f_full;
    logic         f_afull;
    logic         done;
    logic         err;

    always #5 clk = ~clk;

    aes_axi_stream_slave dut (
        .s00_axis_aclk       (clk),
        .s00_axis_aresetn    (aresetn),
        .s00_axis_tdata      (tdata),
        .s00_axis_tstrb      (tstrb),
        .s00_axis_tvalid     (tvalid),
        .s00_axis_tlast      (tlast),
        .s00_axis_tready     (tready),
        .in_fifo_read_tready (rd_tready),
        .in_fifo_read_tvalid (rd_tvalid),
        .in_fifo_data        (rd_data),
        .in_fifo_empty       (f_empty),
        .in_fifo_full        (f_full),
        .in_fifo_almost_full (f_afull),
        .axis_slave_done     (done),
        .axis_slave_err      (err)
    );

    logic [31:0]  wbuf[$];
    logic [127:0] mq[$];
    logic [127:0] got_q[$];
    logic [127:0] want_q[$];
    int total = 0;
    int bad = 0;
    int done_seen = 0;
    int err_seen = 0;
    int err_model = 0;
    int tready_low = 0;
    bit last_acc;

    // One clock: observe handshakes before the edge, update the model, then advance.
    task automatic step();
        logic [127:0] b;
        #2;
        last_acc = tvalid && tready;
        if (done) done_seen++;
        if (err) err_seen++;
        if (aresetn && !tready) tready_low++;
        if (!aresetn) begin
            wbuf.delete();
            mq.delete();
        end else begin
            if (rd_tvalid && rd_tready) begin
                got_q.push_back(rd_data);
                if (mq.size() > 0) want_q.push_back(mq.pop_front());
                else want_q.push_back('x);
            end
            if (last_acc) begin
                wbuf.push_back(tdata);
                if (wbuf.size() == 4 || tlast) begin
                    if (wbuf.size() == 4 || PAD) begin
                        b = '0;
                        for (int i = 0; i < wbuf.size(); i++) b[127-32*i -: 32] = wbuf[i];
                        mq.push_back(b);
                    end else begin
                        err_model++;
                    end
                    wbuf.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_word(input logic [31:0] d, input bit last);
        bit ok = 1'b0;
        tdata = d;
        tlast = last;
        tvalid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (last_acc) begin
                ok = 1'b1;
                break;
            end
        end
        tvalid = 1'b0;
        tlast = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL send_word_timeout: word %h not accepted, want accepted", d); end
    endtask

    task automatic pop_one();
        rd_tready = 1'b1;
        step();
        rd_tready = 1'b0;
    endtask

    task automatic drain();
        rd_tready = 1'b1;
        idle(20);
        rd_tready = 1'b0;
    endtask

    task automatic clear_obs();
        got_q.delete();
        want_q.delete();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tvalid = 1'b1;
        tdata = 32'hDEADBEEF;
        idle(3);
        total++; if (tready !== 1'b0) begin bad++; $display("FAIL reset_tready: got %b want 0", tready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (f_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", f_empty); end
        total++; if (rd_tvalid !== 1'b0) begin bad++; $display("FAIL reset_rd_tvalid: got %b want 0", rd_tvalid); end
        total++; if (f_full !== 1'b0 || f_afull !== 1'b0) begin bad++; $display("FAIL reset_full: got %b%b want 00", f_full, f_afull); end
        total++; if (dut.word_cnt !== 2'd0) begin bad++; $display("FAIL reset_word_cnt: got %0d want 0", dut.word_cnt); end
        total++; if (dut.blk !== 128'd0) begin bad++; $display("FAIL reset_blk: got %h want 0", dut.blk); end
        tvalid = 1'b0;
        aresetn = 1'b1;
        step();
        total++; if (tready !== 1'b1) begin bad++; $display("FAIL reset_release_tready: got %b want 1", tready); end
    endtask

    task automatic test_single_block();
        int tl0 = tready_low;
        int d0 = done_seen;
        clear_obs();
        send_word(32'h00112233, 1'b0);
        send_word(32'h44556677, 1'b0);
        send_word(32'h8899AABB, 1'b0);
        send_word(32'hCCDDEEFF, 1'b1);
        total++; if (tready !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL single_push_cycle: tready=%b done=%b want 0 1", tready, done); end
        total++; if (f_empty !== 1'b1) begin bad++; $display("FAIL single_latency: empty=%b want 1 before push edge", f_empty); end
        step();
        total++; if (f_empty !== 1'b0 || tready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL single_after_push: empty=%b tready=%b done=%b want 0 1 0", f_empty, tready, done); end
        idle(2);
        total++; if (tready_low - tl0 != 1) begin bad++; $display("FAIL single_tready_low: got %0d cycles want 1", tready_low - tl0); end
        total++; if (done_seen - d0 != 1) begin bad++; $display("FAIL single_done_count: got %0d want 1", done_seen - d0); end
        pop_one();
        total++; if (got_q.size() != 1 || got_q[0] !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin bad++; $display("FAIL single_data: got %h want 00112233445566778899aabbccddeeff", got_q.size() > 0 ? got_q[0] : 128'hx); end
        total++; if (f_empty !== 1'b1) begin bad++; $display("FAIL single_empty_after_pop: got %b want 1", f_empty); end
    endtask

    task automatic test_short_block();
        int d0 = done_seen;
        int e0 = err_seen;
        logic [31:0] w[4];
        clear_obs();
        send_word(32'h0000000A, 1'b0);
        send_word(32'h0000000B, 1'b0);
        send_word(32'h0000000C, 1'b1);
        if (PAD) begin
            total++; if (done !== 1'b1 || err !== 1'b0 || tready !== 1'b0) begin bad++; $display("FAIL pad_push_cycle: done=%b err=%b tready=%b want 1 0 0", done, err, tready); end
            step();
            total++; if (f_empty !== 1'b0) begin bad++; $display("FAIL pad_written: empty=%b want 0", f_empty); end
            pop_one();
            total++; if (got_q.size() != 1 || got_q[0] !== 128'h0000000A_0000000B_0000000C_00000000) begin bad++; $display("FAIL pad_data: got %h want 0000000a0000000b0000000c00000000", got_q.size() > 0 ? got_q[0] : 128'hx); end
            total++; if (err_seen != e0) begin bad++; $display("FAIL pad_no_err: got %0d err pulses want 0", err_seen - e0); end
        end else begin
            total++; if (err !== 1'b1 || tready !== 1'b1 || f_empty !== 1'b1) begin bad++; $display("FAIL drop_cycle: err=%b tready=%b empty=%b want 1 1 1", err, tready, f_empty); end
            step();
            total++; if (err !== 1'b0 || f_empty !== 1'b1) begin bad++; $display("FAIL drop_after: err=%b empty=%b want 0 1", err, f_empty); end
            total++; if (done_seen != d0 || err_seen - e0 != 1) begin bad++; $display("FAIL drop_pulses: done=%0d err=%0d want 0 1", done_seen - d0, err_seen - e0); end
        end
        total++; if (dut.word_cnt !== 2'd0) begin bad++; $display("FAIL short_word_cnt: got %0d want 0", dut.word_cnt); end
        clear_obs();
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            send_word(w[i], i == 3);
        end
        idle(1);
        pop_one();
        total++; if (got_q.size() != 1 || got_q[0] !== {w[0], w[1], w[2], w[3]}) begin bad++; $display("FAIL short_followup: got %h want %h", got_q.size() > 0 ? got_q[0] : 128'hx, {w[0], w[1], w[2], w[3]}); end
    endtask

    task automatic test_fill_full();
        clear_obs();
        for (int b = 0; b < 16; b++)
            for (int i = 0; i < 4; i++) send_word($urandom, i == 3);
        idle(1);
        total++; if (f_full !== 1'b1 || tready !== 1'b0 || f_afull !== 1'b1) begin bad++; $display("FAIL full_state: full=%b tready=%b afull=%b want 1 0 1", f_full, tready, f_afull); end
        pop_one();
        total++; if (tready !== 1'b1 || f_full !== 1'b0) begin bad++; $display("FAIL full_pop_tready: tready=%b full=%b want 1 0", tready, f_full); end
        for (int i = 0; i < 4; i++) send_word($urandom, i == 3);
        idle(1);
        total++; if (f_full !== 1'b1) begin bad++; $display("FAIL full_refill: full=%b want 1", f_full); end
        drain();
        total++; if (got_q.size() != 17) begin bad++; $display("FAIL full_count: got %0d blocks want 17", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            total++; if (got_q[i] !== want_q[i]) begin bad++; $display("FAIL full_block_%0d: got %h want %h", i, got_q[i], want_q[i]); end
        end
    endtask

    task automatic test_random_stream();
        clear_obs();
        rd_tready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            idle($urandom_range(0, 2));
            rd_tready = 1'b1;
            send_word($urandom, (i % 4) == 3);
        end
        drain();
        total++; if (got_q.size() != 16 || mq.size() != 0) begin bad++; $display("FAIL stream_count: got %0d blocks (%0d left) want 16 (0)", got_q.size(), mq.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            total++; if (got_q[i] !== want_q[i]) begin bad++; $display("FAIL stream_block_%0d: got %h want %h", i, got_q[i], want_q[i]); end
        end
    endtask

    task automatic test_reset_mid_block();
        logic [31:0] n[4];
        clear_obs();
        send_word($urandom, 1'b0);
        send_word($urandom, 1'b0);
        aresetn = 1'b0;
        idle(2);
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n[i] = $urandom;
            send_word(n[i], i == 3);
        end
        idle(1);
        total++; if (f_empty !== 1'b0) begin bad++; $display("FAIL midrst_entry: empty=%b want 0", f_empty); end
        pop_one();
        total++; if (got_q.size() != 1 || got_q[0] !== {n[0], n[1], n[2], n[3]}) begin bad++; $display("FAIL midrst_data: got %h want %h", got_q.size() > 0 ? got_q[0] : 128'hx, {n[0], n[1], n[2], n[3]}); end
        total++; if (f_empty !== 1'b1) begin bad++; $display("FAIL midrst_single: empty=%b want 1", f_empty); end
        for (int i = 0; i < 4; i++) send_word($urandom, i == 3);
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        idle(2);
        total++; if (f_empty !== 1'b1 || rd_tvalid !== 1'b0) begin bad++; $display("FAIL pushrst_discard: empty=%b rd_tvalid=%b want 1 0", f_empty, rd_tvalid); end
    endtask

    task automatic test_push_pop();
        logic [31:0] a[4];
        logic [31:0] b[4];
        clear_obs();
        for (int i = 0; i < 4; i++) begin
            a[i] = $urandom;
            send_word(a[i], i == 3);
        end
        idle(1);
        for (int i = 0; i < 4; i++) begin
            b[i] = $urandom;
            send_word(b[i], i == 3);
        end
        rd_tready = 1'b1;
        step();
        rd_tready = 1'b0;
        total++; if (f_empty !== 1'b0 || dut.u_fifo.count !== 5'd1) begin bad++; $display("FAIL pushpop_occupancy: empty=%b count=%0d want 0 1", f_empty, dut.u_fifo.count); end
        pop_one();
        total++; if (f_empty !== 1'b1) begin bad++; $display("FAIL pushpop_drained: empty=%b want 1", f_empty); end
        total++; if (got_q.size() != 2 || got_q[0] !== {a[0], a[1], a[2], a[3]} || got_q[1] !== {b[0], b[1], b[2], b[3]}) begin bad++; $display("FAIL pushpop_order: got %0d blocks first %h want 2 blocks first %h", got_q.size(), got_q.size() > 0 ? got_q[0] : 128'hx, {a[0], a[1], a[2], a[3]}); end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_short_block();
        test_fill_full();
        test_random_stream();
        test_reset_mid_block();
        test_push_pop();
        total++; if (err_seen != err_model) begin bad++; $display("FAIL err_pulse_total: got %0d want %0d", err_seen, err_model); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_axi_stream_slave.md
AES_AXI_STREAM_SLAVE -- requirements
Module: aes_axi_stream_slave

Interface
REQ-001 The block SHALL have parameter C_S_AXIS_TDATA_WIDTH, default 32: slave bus width (only 32 supported).
REQ-002 The block SHALL have parameter FIFO_SIZE, default 16: input FIFO depth in 128-bit blocks.
REQ-003 The block SHALL have parameter FIFO_ADDR_WIDTH, default 4: FIFO address width.
REQ-004 The block SHALL have parameter FIFO_DATA_WIDTH, default 128: AES block width.
REQ-005 The block SHALL have port s00_axis_aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port s00_axis_aresetn, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port s00_axis_tdata, input, C_S_AXIS_TDATA_WIDTH bits: stream word.
REQ-008 The block SHALL have port s00_axis_tstrb, input, C_S_AXIS_TDATA_WIDTH/8 bits: ignored; all bytes are treated as valid.
REQ-009 The block SHALL have ports s00_axis_tvalid (input, 1), s00_axis_tlast (input, 1) and s00_axis_tready (output, 1): AXI-Stream handshake.
REQ-010 The block SHALL have port in_fifo_read_tready, input, 1 bit: the AES controller pops one block.
REQ-011 The block SHALL have ports in_fifo_read_tvalid (output, 1) and in_fifo_data (output, FIFO_DATA_WIDTH): head block of the FIFO.
REQ-012 The block SHALL have ports in_fifo_empty, in_fifo_full and in_fifo_almost_full, each an output of 1 bit: FIFO status.
REQ-013 The block SHALL have port axis_slave_done, output reg, 1 bit: one-cycle pulse when the tlast block is written to the FIFO.
REQ-014 The block SHALL have port axis_slave_err, output reg, 1 bit: one-cycle pulse when a partial block is dropped.

Function
REQ-015 The block SHALL instantiate the team fifo (ADDR_WIDTH, DATA_WIDTH, DEPTH = FIFO_SIZE), with reset = !s00_axis_aresetn.
REQ-016 A word SHALL be accepted when s00_axis_tvalid && s00_axis_tready.
REQ-017 Assembly SHALL proceed MSW-first: each accepted word is loaded with blk <= {blk[95:0], tdata}, so word 0 lands in bits [127:96].
REQ-018 word_cnt SHALL be 2 bits, count 0..3, increment on every accepted word, and wrap to 0 after word 3.
REQ-019 The FSM SHALL have two states: S_COLLECT and S_PUSH; reset enters S_COLLECT.
REQ-020 In S_COLLECT, accepting word 3 (word_cnt == 3) SHALL transition to S_PUSH.
REQ-021 In S_PUSH, the block SHALL assert fifo_write_tvalid for exactly one cycle with wdata = blk, then return to S_COLLECT.
REQ-022 Latency: word 3 accepted at cycle N SHALL result in the FIFO write at cycle N+1.
REQ-023 s00_axis_tready SHALL equal s00_axis_aresetn && (state == S_COLLECT) && !in_fifo_full.
REQ-024 Because this block is the FIFO's only writer, the FIFO SHALL never become full between acceptance of word 3 and the push.
REQ-025 A tlast accepted with word_cnt == 3 SHALL cause axis_slave_done to pulse in the S_PUSH cycle.
REQ-026 A tlast accepted with word_cnt < 3 SHALL be handled per REQ-033/REQ-034, and word_cnt SHALL return to 0 afterwards.
REQ-027 FIFO read side: in_fifo_read_tvalid SHALL be driven from the fifo read tvalid, and a pop occurs on in_fifo_read_tready && in_fifo_read_tvalid.
REQ-028 A simultaneous pop and push SHALL both take effect in the same cycle.
REQ-029 A pop from a full FIFO SHALL permit tready in the following cycle.
REQ-030 A tlast on a non-boundary word with no following traffic SHALL leave no residual state.

Reset
REQ-031 While s00_axis_aresetn is low, the block SHALL hold: s00_axis_tready=0, axis_slave_done=0, axis_slave_err=0, word_cnt=0, blk=0, state=S_COLLECT, FIFO empty (in_fifo_empty=1, in_fifo_read_tvalid=0, in_fifo_full=0, in_fifo_almost_full=0).
REQ-032 Reset asserted mid-block or during S_PUSH SHALL discard the partial or pending block, with no FIFO write.

Configuration
REQ-033 With AES_AXIS_SLAVE_PAD_EN defined, a short tlast block SHALL be zero-padded in its low words (blk shifted left by (3-word_cnt)*32), then go to S_PUSH, be written, and pulse axis_slave_done; axis_slave_err SHALL stay 0.
REQ-034 With AES_AXIS_SLAVE_PAD_EN undefined, a short tlast block SHALL be dropped: no FIFO write, axis_slave_err pulses the next cycle, state remains S_COLLECT.

Verification
REQ-035 The bench SHALL drive words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with tlast on the 4th -> one FIFO entry 0x00112233_44556677_8899AABB_CCDDEEFF, axis_slave_done pulses once, tready low for exactly one cycle.
REQ-036 The bench SHALL fill 16 blocks with no pops -> in_fifo_full=1, tready=0; one pop -> tready=1 next cycle, and the 17th block is accepted intact.
REQ-037 The bench SHALL drive 3 words 0xA, 0xB, 0xC with tlast on 0xC -> PAD_EN: entry 0x0000000A_0000000B_0000000C_00000000 and done pulse; without PAD_EN: no entry and axis_slave_err pulses.
REQ-038 The bench SHALL toggle tvalid randomly with continuous pops over 64 words -> 16 blocks in order, no word lost or duplicated.
REQ-039 The bench SHALL assert reset after 2 words, then send a 4-word block -> FIFO holds only the new block, and word_cnt restarts at 0.
REQ-040 The bench SHALL perform a push and a pop in the same cycle with the FIFO holding 1 block -> occupancy stays 1, in_fifo_empty stays 0.
